// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; ovf is carried only with SERIAL_SUB_OVF_EN.
// The master drives start/a/b; the slave returns d/bout/busy/done.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input  d, bout, busy, done, ovf);
    modport slave  (input  start, a, b, output d, bout, busy, done, ovf);
`else
    modport master (output start, a, b, input  d, bout, busy, done);
    modport slave  (input  start, a, b, output d, bout, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a-b, LSB first, one borrow cell; signed ovf output with SERIAL_SUB_OVF_EN.
// Latency WIDTH cycles accept-to-done; start ignored while busy/done, no queueing or backpressure.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave sub
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbit;
    logic             bnext;
    logic [WIDTH-1:0] r_next;
`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are shifted out of a_q/b_q, so keep them for the overflow term.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    assign dbit   = a_q[0] ^ b_q[0] ^ br_q;
    assign bnext  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign r_next = {dbit, r_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (sub.start) begin
                    state_d = SHIFT;
                    a_d     = sub.a;
                    b_d     = sub.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = sub.a[WIDTH-1];
                    b_msb_d = sub.b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = bnext;
                r_d   = r_next[WIDTH-1:1];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    d_d     = r_next;
                    bout_d  = bnext;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q ^ b_msb_q) & (dbit ^ a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sub.d    = d_q;
    assign sub.bout = bout_q;
    assign sub.busy = (state_q == SHIFT);
    assign sub.done = (state_q == DONE);
`ifdef SERIAL_SUB_OVF_EN
    assign sub.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 directed cases plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor;
    typedef struct packed {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .sub(if8.slave));
    serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .sub(if4.slave));

    exp_t q8[$];
    exp_t q4[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
        exp_t       e;
        logic [7:0] diff;
        logic [7:0] msk;
        int         m;
        msk    = 8'((1 << w) - 1);
        diff   = (a - b) & msk;
        m      = w - 1;
        e.d    = diff;
        e.bout = (a < b);
        e.ovf  = (a[m] ^ b[m]) & (diff[m] ^ a[m]);
        return e;
    endfunction

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit push);
        if8.a     = a;
        if8.b     = b;
        if8.start = 1'b1;
        if (push) q8.push_back(model(8, a, b));
        @(negedge clk);
        if8.start = 1'b0;
        if8.a     = ~a;
        if8.b     = ~b;
    endtask

    task automatic wait_done8(input int exp_lat);
        int k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (if8.done) begin
                k = i;
                break;
            end
        end
        chk("latency8", k, exp_lat);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if8.done) begin
            chk("busy_at_done8", 32'(if8.busy), 0);
            chk("expected_done8", 32'(q8.size() > 0), 1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("d8", 32'(if8.d), 32'(e.d));
                chk("bout8", 32'(if8.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf8", 32'(if8.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if4.done) begin
            chk("busy_at_done4", 32'(if4.busy), 0);
            chk("expected_done4", 32'(q4.size() > 0), 1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("d4", 32'(if4.d), 32'(e.d));
                chk("bout4", 32'(if4.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf4", 32'(if4.ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;
        #1;
        chk("rst_d8", 32'(if8.d), 0);
        chk("rst_bout8", 32'(if8.bout), 0);
        chk("rst_busy8", 32'(if8.busy), 0);
        chk("rst_done8", 32'(if8.done), 0);
        chk("rst_d4", 32'(if4.d), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf8", 32'(if8.ovf), 0);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue8(8'h05, 8'h03, 1'b1); chk("busy_after_accept", 32'(if8.busy), 1); wait_done8(8);
        issue8(8'h03, 8'h05, 1'b1); wait_done8(8);
        issue8(8'h80, 8'h01, 1'b1); wait_done8(8);
        issue8(8'h00, 8'h00, 1'b1); wait_done8(8);

        // start held high mid-SHIFT must not launch a second operation
        issue8(8'hFF, 8'h01, 1'b1);
        if8.start = 1'b1; if8.a = 8'h00; if8.b = 8'hFF;
        repeat (3) @(negedge clk);
        if8.start = 1'b0;
        wait_done8(5);
        repeat (12) @(negedge clk);
        chk("q8_after_hold", q8.size(), 0);

        // asynchronous reset in the middle of an operation
        issue8(8'h05, 8'h03, 1'b1); wait_done8(8);
        chk("d_before_rst", 32'(if8.d), 32'h02);
        issue8(8'h44, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_d8", 32'(if8.d), 0);
        chk("arst_bout8", 32'(if8.bout), 0);
        chk("arst_busy8", 32'(if8.busy), 0);
        chk("arst_done8", 32'(if8.done), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("idle_after_rst", 32'(if8.busy), 0);
        issue8(8'h10, 8'h01, 1'b1); wait_done8(8);

        // exhaustive WIDTH=4 sweep at the minimum issue interval
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if4.a     = 4'(a);
                if4.b     = 4'(b);
                if4.start = 1'b1;
                q4.push_back(model(4, 8'(a), 8'(b)));
                @(negedge clk);
                if4.start = 1'b0;
                repeat (5) @(negedge clk);
            end
        end
        for (int i = 0; i < 40 && (q4.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
